// File: rtl/tmds_video_encoder.sv
// tmds_video_encoder: raster timing, test-pattern sources and a 3-stage TMDS encoder per channel.
module tmds_video_encoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          pix_clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    input  logic [23:0]   pix_rgb,
    output logic          pix_req,
    output logic          frame_start,
    output logic [HW-1:0] x_pos,
    output logic [VW-1:0] y_pos,
    output logic [9:0]    tmds_r,
    output logic [9:0]    tmds_g,
    output logic [9:0]    tmds_b
);
    function automatic logic [3:0] ones(input logic [7:0] d);
        ones = '0;
        for (int i = 0; i < 8; i++) ones = ones + {3'b0, d[i]};
    endfunction

    // XNOR is XOR with an inverted result, so a single xor term covers both
    function automatic logic [8:0] qm(input logic [7:0] d);
        logic x;
        x = ones(d) > 4'd4 || (ones(d) == 4'd4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ x;
        qm[8] = !x;
    endfunction

    function automatic logic [9:0] tok(input logic [1:0] c);
        tok = c == 2'b00 ? 10'b1101010100 : c == 2'b01 ? 10'b0010101011 :
              c == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    endfunction

    logic [HW-1:0]    r_h, w_bar_idx;
    logic [VW-1:0]    r_v;
    logic [1:0]       r_mode, w_mode, r_s1_c, r_s2_c;
    logic             w_h_last, w_de, w_hs, w_vs, w_c0, w_c1, r_s1_de, r_s2_de;
    logic [2:0]       w_bar;
    logic [7:0]       w_grad;
    logic [23:0]      w_bars, w_rgb, r_s1_rgb;
    logic [2:0][9:0]  w_tmds;

    // the new mode is used from the frame_start pixel onward, then held for the frame
    always_comb begin
        w_h_last    = r_h == HW'(H_TOTAL - 1);
        frame_start = r_h == '0 && r_v == '0 && !rst;
        w_mode      = frame_start ? mode : r_mode;
        w_de        = r_h < HW'(H_ACTIVE) && r_v < VW'(V_ACTIVE);
        w_hs        = r_h >= HW'(H_ACTIVE + H_FP) && r_h < HW'(H_ACTIVE + H_FP + H_SYNC);
        w_vs        = r_v >= VW'(V_ACTIVE + V_FP) && r_v < VW'(V_ACTIVE + V_FP + V_SYNC);
        w_c0        = HS_POL != 0 ? w_hs : !w_hs;
        w_c1        = VS_POL != 0 ? w_vs : !w_vs;
        pix_req     = w_de && w_mode == 2'b00;
        w_bar_idx   = r_h / HW'(H_ACTIVE / 8);
        w_bar       = w_bar_idx > HW'(7) ? 3'd7 : w_bar_idx[2:0];
        w_bars      = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
        w_grad      = 8'(r_h);
        w_rgb       = w_mode == 2'b01 ? solid_rgb : w_mode == 2'b10 ? w_bars :
                      w_mode == 2'b11 ? {3{w_grad}} : pix_rgb;
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_h      <= '0;
            r_v      <= '0;
            r_mode   <= 2'b00;
            r_s1_rgb <= '0;
            r_s1_de  <= 1'b0;
            r_s1_c   <= 2'b00;
            r_s2_de  <= 1'b0;
            r_s2_c   <= 2'b00;
        end else begin
            r_h      <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last) r_v <= r_v == VW'(V_TOTAL - 1) ? '0 : r_v + 1'b1;
            r_mode   <= w_mode;
            r_s1_rgb <= w_rgb;
            r_s1_de  <= w_de;
            r_s1_c   <= {w_c1, w_c0};
            r_s2_de  <= r_s1_de;
            r_s2_c   <= r_s1_c;
        end
    end

    // channel 0 = blue (carries sync), 1 = green, 2 = red
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [8:0]        r_qm, w_qm;
        logic [3:0]        r_n1;
        logic [9:0]        r_tmds, w_word;
        logic signed [4:0] r_cnt, w_cnt, w_d;
        logic [1:0]        w_ctl;
        logic              w_q8;
        always_comb begin
            w_qm  = qm(r_s1_rgb[c*8 +: 8]);
            w_q8  = r_qm[8];
            w_ctl = c == 0 ? r_s2_c : 2'b00;
            w_d   = {r_n1, 1'b0} - 5'd8;
            if (!r_s2_de) begin
                w_word = tok(w_ctl);
                w_cnt  = '0;
            end else if (r_cnt == 0 || r_n1 == 4'd4) begin
                w_word = {~w_q8, w_q8, w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt  = w_q8 ? r_cnt + w_d : r_cnt - w_d;
            end else if ((r_cnt > 0 && r_n1 > 4'd4) || (r_cnt < 0 && r_n1 < 4'd4)) begin
                w_word = {1'b1, w_q8, ~r_qm[7:0]};
                w_cnt  = r_cnt + {3'b0, w_q8, 1'b0} - w_d;
            end else begin
                w_word = {1'b0, w_q8, r_qm[7:0]};
                w_cnt  = r_cnt - {3'b0, ~w_q8, 1'b0} + w_d;
            end
        end
        always_ff @(posedge pix_clk) begin
            if (rst) begin
                r_qm   <= '0;
                r_n1   <= '0;
                r_tmds <= 10'b1101010100;
                r_cnt  <= '0;
            end else begin
                r_qm   <= w_qm;
                r_n1   <= ones(w_qm[7:0]);
                r_tmds <= w_word;
                r_cnt  <= w_cnt;
            end
        end
        assign w_tmds[c] = r_tmds;
    end

    assign x_pos  = r_h;
    assign y_pos  = r_v;
    assign tmds_r = w_tmds[2];
    assign tmds_g = w_tmds[1];
    assign tmds_b = w_tmds[0];
endmodule
